out_port_ctrl: RTL and testbench
================================

Name: out_port_ctrl

Overview:
- Output-side I/O controller for the basic computer: holds the OUTR register and the FGO flag.
- Transmits one character per OUT instruction to an external device over a four-phase req/ack handshake.
- Counterpart of the input path (INPR/FGI), which receives characters from the device.
- Feeds FGO to the control unit for SKO and for interrupt generation.

Parameters:
- DATA_W, 8, width of OUTR and of the device data bus
- TO_CYCLES, 255, clock cycles to wait for an ack edge before aborting; 0 disables the timeout
- CNT_W, 8, timeout counter width; must satisfy TO_CYCLES < 2**CNT_W

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (reset==0 clears the block immediately)
- outr_ld  input  1  one-cycle pulse from control unit executing OUT
- ac_in  input  DATA_W  low bits of AC, captured into OUTR on accepted outr_ld
- ien  input  1  interrupt-enable flip-flop value
- err_clr  input  1  clears the sticky error flags
- dev_ack  input  1  device acknowledge; synchronised internally with 2 flops
- dev_req  output  1  request to device; data valid while high
- dev_data  output  DATA_W  OUTR contents
- fgo  output  1  output flag: 1 = ready for a new character
- fgo_rise  output  1  one-cycle pulse when fgo goes 0->1
- int_out  output  1  registered fgo & ien
- ovr_err  output  1  sticky: outr_ld arrived while fgo==0
- to_err  output  1  sticky: handshake aborted by timeout

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE; fgo=1; OUTR=0; dev_req=0.
  - fgo_rise=0, int_out=0, ovr_err=0, to_err=0.
  - Timeout counter=0; synchroniser flops=0.
  - Reset mid-handshake drops dev_req immediately; the character is lost.
- IDLE (dev_req=0, fgo=1):
  - On outr_ld: OUTR<=ac_in and fgo<=0 in the same edge; counter<=0; go to REQ.
- REQ (dev_req=1 as a registered output, first high the cycle after the load):
  - When synced ack==1: go to RELEASE, counter<=0.
- RELEASE (dev_req=0):
  - When synced ack==0: go to IDLE, fgo<=1, fgo_rise=1 for exactly one cycle.
- Timeout:
  - In REQ and RELEASE the counter increments each cycle.
  - If TO_CYCLES!=0 and the counter reaches TO_CYCLES with no qualifying ack edge: go to IDLE, fgo<=1, to_err<=1, fgo_rise pulses, dev_req<=0.
  - The counter saturates and never wraps.
- outr_ld while fgo==0:
  - Ignored; OUTR unchanged, no state change, ovr_err<=1.
- outr_ld on the same edge the block returns to IDLE:
  - fgo is still 0 at that edge, so the load is treated as overrun and ignored.
- err_clr clears ovr_err and to_err.
  - If err_clr and a new error occur on the same edge, set wins.
- int_out <= fgo & ien every cycle (one-cycle latency). The control unit clears ien on interrupt entry.
- dev_data always equals OUTR; it changes only on an accepted load, never while dev_req==1.
- Ack-to-fgo latency: 2 sync cycles + 1 state cycle after the ack falls.
- Illegal state encodings recover to IDLE with fgo=1.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, REQ, RELEASE)
  - DATA_W default
  - sync depth constant (2)
- One sub-module, sync_2ff: a two-flop synchroniser for dev_ack with the same clk/reset. It is reusable by the input-side controller.

Test Plan:
- Reset release, no stimulus -> fgo=1, dev_req=0, dev_data=0x00, int_out=0, no errors.
- ac_in=0xA5, outr_ld pulse; device acks 3 cycles after dev_req, releases 2 cycles later:
  - dev_data=0xA5 and fgo=0 the cycle after the load; dev_req high the next cycle.
  - dev_req falls 3 cycles after ack rises (2 sync + 1).
  - fgo=1 plus a single fgo_rise pulse 3 cycles after ack falls.
- Second outr_ld (ac_in=0x3C) while fgo=0 -> OUTR stays 0xA5, ovr_err=1; err_clr pulse -> ovr_err=0.
- TO_CYCLES=4, device never acks -> after 4 cycles in REQ: dev_req=0, fgo=1, to_err=1, fgo_rise pulse.
- ien=1 during a full transfer -> int_out=0 while busy, int_out=1 one cycle after fgo returns to 1.
- reset asserted while in REQ with dev_req=1 -> dev_req=0 and fgo=1 immediately (asynchronous); after release a new load of 0x5A completes normally.

Source files
------------

// File: rtl/out_port_ctrl_pkg.sv
// Shared types and constants for the basic-computer output port controller.
package out_port_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/out_port_ctrl_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit device signal.
module sync_2ff
  import out_port_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[SYNC_DEPTH-2:0], d};
  end

  assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/out_port_ctrl.sv
// OUTR/FGO output controller: four-phase req/ack transmit with timeout and sticky errors.
module out_port_ctrl
  import out_port_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              outr_ld,
  input  logic [DATA_W-1:0] ac_in,
  input  logic              ien,
  input  logic              err_clr,
  input  logic              dev_ack,
  output logic              dev_req,
  output logic [DATA_W-1:0] dev_data,
  output logic              fgo,
  output logic              fgo_rise,
  output logic              int_out,
  output logic              ovr_err,
  output logic              to_err
);

  state_t              state_q, state_n;
  logic                fgo_q, fgo_n;
  logic [DATA_W-1:0]   outr_q, outr_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n, cnt_inc;
  logic                req_q, req_n;
  logic                rise_q, rise_n;
  logic                int_q, int_n;
  logic                ovr_q, ovr_n;
  logic                to_q, to_n;
  logic                ack_s;
  logic                timeout;
  logic                done;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (dev_ack),
    .q     (ack_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      fgo_q   <= 1'b1;
      outr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      rise_q  <= 1'b0;
      int_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      fgo_q   <= fgo_n;
      outr_q  <= outr_n;
      cnt_q   <= cnt_n;
      req_q   <= req_n;
      rise_q  <= rise_n;
      int_q   <= int_n;
      ovr_q   <= ovr_n;
      to_q    <= to_n;
    end
  end

  // Saturating counter; timeout fires on the edge the count reaches TO_CYCLES.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (TO_CYCLES != 0) && (cnt_inc == CNT_W'(TO_CYCLES));

  always_comb begin
    state_n = state_q;
    fgo_n   = fgo_q;
    outr_n  = outr_q;
    cnt_n   = cnt_q;
    ovr_n   = ovr_q;
    to_n    = to_q;
    done    = 1'b0;

    if (err_clr) begin
      ovr_n = 1'b0;
      to_n  = 1'b0;
    end
    if (outr_ld && !fgo_q) ovr_n = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (outr_ld && fgo_q) begin
          outr_n  = ac_in;
          fgo_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_n = ST_RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          if (timeout) begin
            done = 1'b1;
            to_n = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          done = 1'b1;
        end else begin
          cnt_n = cnt_inc;
          if (timeout) begin
            done = 1'b1;
            to_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        fgo_n   = 1'b1;
      end
    endcase

    if (done) begin
      state_n = ST_IDLE;
      fgo_n   = 1'b1;
    end

    // dev_req registered from next state so it tracks the state without lag.
    req_n  = (state_n == ST_REQ);
    rise_n = fgo_n & ~fgo_q;
    int_n  = fgo_q & ien;
  end

  assign dev_req  = req_q;
  assign dev_data = outr_q;
  assign fgo      = fgo_q;
  assign fgo_rise = rise_q;
  assign int_out  = int_q;
  assign ovr_err  = ovr_q;
  assign to_err   = to_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Self-checking bench for out_port_ctrl: directed table, corner sequences, random vs. model.
module tb_out_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ac_in;
  logic       ien, err_clr;
  logic       ld0, ack0, ld1, ack1;
  logic       dev_req0, fgo0, fgo_rise0, int_out0, ovr_err0, to_err0;
  logic       dev_req1, fgo1, fgo_rise1, int_out1, ovr_err1, to_err1;
  logic [7:0] dev_data0, dev_data1;
  logic [13:0] o0, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_port_ctrl dut (
    .clk(clk), .reset(reset), .outr_ld(ld0), .ac_in(ac_in), .ien(ien),
    .err_clr(err_clr), .dev_ack(ack0), .dev_req(dev_req0), .dev_data(dev_data0),
    .fgo(fgo0), .fgo_rise(fgo_rise0), .int_out(int_out0), .ovr_err(ovr_err0),
    .to_err(to_err0)
  );

  out_port_ctrl #(.TO_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .outr_ld(ld1), .ac_in(ac_in), .ien(ien),
    .err_clr(err_clr), .dev_ack(ack1), .dev_req(dev_req1), .dev_data(dev_data1),
    .fgo(fgo1), .fgo_rise(fgo_rise1), .int_out(int_out1), .ovr_err(ovr_err1),
    .to_err(to_err1)
  );

  assign o0 = {dev_req0, dev_data0, fgo0, fgo_rise0, int_out0, ovr_err0, to_err0};
  assign o1 = {dev_req1, dev_data1, fgo1, fgo_rise1, int_out1, ovr_err1, to_err1};

  // Transaction-level model: busy flag, handshake phase, elapsed-cycle count, 2-deep ack delay line.
  typedef struct {
    bit       busy;
    bit       phase;
    int       wait_c;
    bit [7:0] outr;
    bit       fgo, req, rise, intr, ovr, to;
    bit [1:0] pipe;
  } mdl_t;

  typedef struct {
    bit        ld;
    bit [7:0]  ac;
    bit        ack;
    bit        ien;
    bit        clr;
    bit [13:0] exp;
  } vec_t;

  mdl_t m0, m1;
  vec_t tbl[15];
  bit   auto0, auto1;
  int   dly0, dly1, max0, max1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{default: 0};
    m.fgo = 1'b1;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, int to_c, bit ld, bit [7:0] ac, bit ie, bit clr, bit ack);
    mdl_t n;
    bit   synced, done;
    n = m;
    synced = m.pipe[1];
    done = 1'b0;
    n.intr = m.fgo & ie;
    n.rise = 1'b0;
    if (clr) begin n.ovr = 1'b0; n.to = 1'b0; end
    if (ld && !m.fgo) n.ovr = 1'b1;
    if (!m.busy) begin
      if (ld) begin
        n.outr = ac; n.fgo = 1'b0; n.busy = 1'b1; n.phase = 1'b0; n.wait_c = 0;
      end
    end else begin
      if (!m.phase && synced) begin
        n.phase = 1'b1; n.wait_c = 0;
      end else if (m.phase && !synced) begin
        done = 1'b1;
      end else begin
        n.wait_c = m.wait_c + 1;
        if (to_c != 0 && n.wait_c == to_c) begin done = 1'b1; n.to = 1'b1; end
      end
      if (done) begin n.busy = 1'b0; n.fgo = 1'b1; n.rise = 1'b1; end
    end
    n.req  = n.busy && !n.phase;
    n.pipe = {m.pipe[0], ack};
    return n;
  endfunction

  function automatic bit [13:0] pack(mdl_t m);
    return {m.req, m.outr, m.fgo, m.rise, m.intr, m.ovr, m.to};
  endfunction

  function automatic bit [13:0] ex(bit rq, bit [7:0] d, bit f, bit r, bit i, bit ov, bit t);
    return {rq, d, f, r, i, ov, t};
  endfunction

  function automatic vec_t mk(bit ld, bit [7:0] ac, bit ack, bit ie, bit clr, bit [13:0] e);
    vec_t v;
    v.ld = ld; v.ac = ac; v.ack = ack; v.ien = ie; v.clr = clr; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: device responders, model step, edge, then compare both DUTs with the model.
  task automatic tick();
    if (auto0 && (dev_req0 != ack0)) begin
      if (dly0 == 0) begin ack0 = dev_req0; dly0 = $urandom_range(0, max0); end
      else dly0--;
    end
    if (auto1 && (dev_req1 != ack1)) begin
      if (dly1 == 0) begin ack1 = dev_req1; dly1 = $urandom_range(0, max1); end
      else dly1--;
    end
    m0 = step(m0, 255, ld0, ac_in, ien, err_clr, ack0);
    m1 = step(m1, 4, ld1, ac_in, ien, err_clr, ack1);
    @(posedge clk);
    #1;
    check("model_main", 32'(o0), 32'(pack(m0)));
    check("model_to", 32'(o1), 32'(pack(m1)));
  endtask

  initial begin
    bit saw_rise;
    int n;
    reset = 1'b0; ac_in = 8'h00; ien = 1'b0; err_clr = 1'b0;
    ld0 = 1'b0; ack0 = 1'b0; ld1 = 1'b0; ack1 = 1'b0;
    auto0 = 1'b0; auto1 = 1'b0; dly0 = 0; dly1 = 0; max0 = 4; max1 = 6;
    m0 = mdl_reset(); m1 = mdl_reset();

    tbl[0]  = mk(1, 8'hA5, 0, 0, 0, ex(1, 8'hA5, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 8'h00, 0, 1, 0, ex(1, 8'hA5, 0, 0, 0, 0, 0));
    tbl[2]  = mk(1, 8'h3C, 0, 1, 0, ex(1, 8'hA5, 0, 0, 0, 1, 0));
    tbl[3]  = mk(0, 8'h00, 1, 1, 0, ex(1, 8'hA5, 0, 0, 0, 1, 0));
    tbl[4]  = mk(0, 8'h00, 1, 1, 0, ex(1, 8'hA5, 0, 0, 0, 1, 0));
    tbl[5]  = mk(0, 8'h00, 1, 1, 0, ex(0, 8'hA5, 0, 0, 0, 1, 0));
    tbl[6]  = mk(0, 8'h00, 1, 1, 0, ex(0, 8'hA5, 0, 0, 0, 1, 0));
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, ex(0, 8'hA5, 0, 0, 0, 1, 0));
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, ex(0, 8'hA5, 0, 0, 0, 1, 0));
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, ex(0, 8'hA5, 1, 1, 0, 1, 0));
    tbl[10] = mk(0, 8'h00, 0, 1, 1, ex(0, 8'hA5, 1, 0, 1, 0, 0));
    tbl[11] = mk(0, 8'h00, 0, 0, 0, ex(0, 8'hA5, 1, 0, 0, 0, 0));
    tbl[12] = mk(1, 8'h11, 0, 0, 0, ex(1, 8'h11, 0, 0, 0, 0, 0));
    tbl[13] = mk(1, 8'h22, 0, 0, 1, ex(1, 8'h11, 0, 0, 0, 1, 0));
    tbl[14] = mk(0, 8'h00, 0, 0, 0, ex(1, 8'h11, 0, 0, 0, 1, 0));

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_main", 32'(o0), 32'(ex(0, 8'h00, 1, 0, 0, 0, 0)));
    check("reset_to", 32'(o1), 32'(ex(0, 8'h00, 1, 0, 0, 0, 0)));

    // Directed A5 transfer with overrun, err_clr, ien and set-wins cases.
    for (int i = 0; i < 15; i++) begin
      ld0 = tbl[i].ld; ac_in = tbl[i].ac; ack0 = tbl[i].ack;
      ien = tbl[i].ien; err_clr = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), 32'(o0), 32'(tbl[i].exp));
    end
    ld0 = 1'b0; err_clr = 1'b0; ien = 1'b0; ac_in = 8'h00;

    // Asynchronous reset while dev_req is high.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {20'h0, dev_req0, fgo0, ovr_err0, dev_data0, 1'b0}, {20'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    m0 = mdl_reset(); m1 = mdl_reset();
    @(negedge clk);
    reset = 1'b1;

    // Fresh 5A transfer completes normally after reset.
    auto0 = 1'b1; dly0 = 2;
    ld0 = 1'b1; ac_in = 8'h5A;
    tick();
    ld0 = 1'b0; ac_in = 8'h00;
    check("load_5a", {23'h0, fgo0, dev_data0}, {23'h0, 1'b0, 8'h5A});
    saw_rise = 1'b0;
    n = 0;
    while (!(fgo0 && saw_rise) && n < 40) begin
      tick();
      if (fgo_rise0) saw_rise = 1'b1;
      n++;
    end
    check("xfer_5a_done", {22'h0, fgo0, saw_rise, dev_data0}, {22'h0, 1'b1, 1'b1, 8'h5A});

    // Timeout on the TO_CYCLES=4 instance with a silent device.
    ld1 = 1'b1; ac_in = 8'h77;
    tick();
    ld1 = 1'b0;
    check("to_load", 32'(o1), 32'(ex(1, 8'h77, 0, 0, 0, 0, 0)));
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), 32'(dev_req1), 32'(1));
    end
    tick();
    check("to_abort", 32'(o1), 32'(ex(0, 8'h77, 1, 1, 0, 0, 1)));
    tick();
    check("to_after", 32'(o1), 32'(ex(0, 8'h77, 1, 0, 0, 0, 1)));

    // Random traffic against the model; slower device on the timeout instance.
    auto1 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ld0 = ($urandom_range(0, 3) == 0);
      ld1 = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      ien = 1'($urandom_range(0, 1));
      ac_in = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
